// File: rtl/ej32_pkg.sv
// Shared types for the mb8 memory-port arbiter: FSM states and the read-return owner tag.
package ej32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

endpackage

// File: rtl/mb8_starve_cnt.sv
// Counts consecutive core grants during a debug burst and flags when debug must take
// the next cycle. Only instantiated when MB8_ARB_FAIR_EN is defined.
module mb8_starve_cnt #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic starved
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt;

    // Saturates at STARVE_MAX; clr wins so a forced debug slot always restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !starved) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starved = (cnt >= CW'(STARVE_MAX));

endmodule

// File: rtl/mb8_arbiter.sv
// Shares one byte-wide memory port between a core and a debug burst reader.
// Define MB8_ARB_FAIR_EN to bound how long a pending burst can be starved by the core.
module mb8_arbiter
    import ej32_pkg::*;
#(
    parameter int AW         = 32,
    parameter int LW         = 12,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [7:0]    core_wdata,
    output logic          core_gnt,
    output logic [7:0]    core_rdata,
    output logic          core_rvalid,
    input  logic          dbg_start,
    input  logic [AW-1:0] dbg_base,
    input  logic [LW-1:0] dbg_len,
    output logic          dbg_busy,
    output logic [7:0]    dbg_data,
    output logic          dbg_valid,
    output logic          dbg_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output arb_state_t    fsm_state
);

    // Handshake: core_req is held until core_gnt=1 in the same cycle; core_rvalid and
    // dbg_valid are single-cycle strobes with no back-pressure, one cycle after the access.

    arb_state_t    state, state_d;
    owner_t        owner, owner_d;
    logic [AW-1:0] ptr, ptr_d;
    logic [LW-1:0] cnt, cnt_d;
    logic          zero_done, zero_done_d;
    logic          dbg_issue;
    logic          force_dbg;

    assign dbg_issue = (state == BURST) && (!core_req || force_dbg);

`ifdef MB8_ARB_FAIR_EN
    mb8_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    ((state == BURST) && core_gnt),
        .clr    (dbg_issue || (state != BURST)),
        .starved(force_dbg)
    );
`else
    // Strict core priority: the fairness bound has no effect in this build.
    assign force_dbg = (STARVE_MAX < 0);
`endif

    always_comb begin
        core_gnt  = core_req;
        mem_addr  = core_addr;
        mem_we    = core_we;
        mem_wdata = core_wdata;
        if (dbg_issue) begin
            core_gnt  = 1'b0;
            mem_addr  = ptr;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end
    end

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        cnt_d       = cnt;
        zero_done_d = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_start) begin
                    if (dbg_len != '0) begin
                        state_d = BURST;
                        ptr_d   = dbg_base;
                        cnt_d   = dbg_len;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            BURST: begin
                if (dbg_issue) begin
                    ptr_d = ptr + 1'b1;
                    cnt_d = cnt - 1'b1;
                    if (cnt == LW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The tag records who owns the byte that the memory returns next cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (dbg_issue) begin
            owner_d = OWN_DBG;
        end else if (core_gnt && !core_we) begin
            owner_d = OWN_CORE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            ptr       <= '0;
            cnt       <= '0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            zero_done <= zero_done_d;
        end
    end

    assign core_rvalid = (owner == OWN_CORE);
    assign dbg_valid   = (owner == OWN_DBG);
    assign core_rdata  = core_rvalid ? mem_rdata : 8'h00;
    assign dbg_data    = dbg_valid ? mem_rdata : 8'h00;
    assign dbg_busy    = (state != IDLE);
    assign dbg_done    = (state == DRAIN) || zero_done;
    assign fsm_state   = state;

endmodule

// File: tb/tb_mb8_arbiter.sv
// Directed bench for mb8_arbiter with a byte memory model and expected-data queues.
// Build with MB8_ARB_FAIR_EN defined to exercise the starvation bound instead of strict priority.
module tb_mb8_arbiter;
    import ej32_pkg::*;

    localparam int AW = 32;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [7:0]    core_wdata;
    logic          core_gnt, core_rvalid;
    logic [7:0]    core_rdata;
    logic          dbg_start;
    logic [AW-1:0] dbg_base;
    logic [LW-1:0] dbg_len;
    logic          dbg_busy, dbg_valid, dbg_done;
    logic [7:0]    dbg_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    arb_state_t    fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    int dbg_cnt = 0;
    int rv_cnt = 0;
    int done_cnt = 0;

    logic [7:0] dbg_exp_q[$];
    logic [7:0] core_exp_q[$];
    logic [7:0] mem_a[logic [31:0]];
    logic [7:0] rd_pipe;

    mb8_arbiter #(.AW(AW), .LW(LW), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rdata (core_rdata),
        .core_rvalid(core_rvalid),
        .dbg_start  (dbg_start),
        .dbg_base   (dbg_base),
        .dbg_len    (dbg_len),
        .dbg_busy   (dbg_busy),
        .dbg_data   (dbg_data),
        .dbg_valid  (dbg_valid),
        .dbg_done   (dbg_done),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory model ----------------
    function automatic logic [7:0] model_rd(input logic [31:0] a);
        if (mem_a.exists(a)) return mem_a[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endfunction

    always @(negedge clk) begin
        if (mem_we) mem_a[mem_addr] = mem_wdata;
        rd_pipe = model_rd(mem_addr);
    end

    always @(posedge clk) mem_rdata <= rd_pipe;

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (core_rvalid && dbg_valid) chk("rvalid_overlap", 1, 0);
            if (dbg_valid) begin
                dbg_cnt++;
                if (dbg_exp_q.size() == 0) chk("dbg_unexpected", 1, 0);
                else chk("dbg_data", {24'h0, dbg_data}, {24'h0, dbg_exp_q.pop_front()});
            end
            if (core_rvalid) begin
                rv_cnt++;
                if (core_exp_q.size() == 0) chk("core_unexpected", 1, 0);
                else chk("core_rdata", {24'h0, core_rdata}, {24'h0, core_exp_q.pop_front()});
            end
            if (dbg_done) done_cnt++;
            if (core_req && core_gnt && !core_we) core_exp_q.push_back(model_rd(core_addr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [31:0] base, input int len, input bit accept);
        dbg_start = 1'b1;
        dbg_base  = base;
        dbg_len   = LW'(len);
        if (accept) begin
            for (int i = 0; i < len; i++) dbg_exp_q.push_back(model_rd(base + 32'(i)));
        end
        step();
        dbg_start = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget);
        int n;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_timeout", (done_cnt != start), 1);
    endtask

    task automatic idle_core();
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0, v0, r0;

        rst = 1'b1;
        idle_core();
        dbg_start = 1'b0;
        dbg_base  = '0;
        dbg_len   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", dbg_busy, 0);
        chk("rst_dvalid", dbg_valid, 0);
        chk("rst_rvalid", core_rvalid, 0);
        chk("rst_done", dbg_done, 0);
        chk("rst_state", fsm_state, IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // core-only reads in IDLE
        for (int i = 0; i < 4; i++) begin
            core_req  = 1'b1;
            core_addr = 32'h1000 + 32'(i);
            @(negedge clk);
            chk("core_gnt_idle", core_gnt, 1);
            chk("core_mem_addr", mem_addr, 32'h1000 + 32'(i));
            chk("core_rvalid_lat", core_rvalid, (i > 0));
            step();
        end
        idle_core();
        @(negedge clk);
        chk("core_rvalid_last", core_rvalid, 1);
        step();
        @(negedge clk);
        chk("core_rvalid_off", core_rvalid, 0);
        step();
        chk("core_rv_count", rv_cnt, 4);

        // core write makes no rvalid; readback returns the written byte
        r0 = rv_cnt;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h2000; core_wdata = 8'h77;
        @(negedge clk);
        chk("wr_gnt", core_gnt, 1);
        chk("wr_mem_we", mem_we, 1);
        step();
        core_we = 1'b0;
        @(negedge clk);
        chk("wr_no_rvalid", core_rvalid, 0);
        step();
        idle_core();
        @(negedge clk);
        chk("wr_readback", {core_rvalid, core_rdata}, {1'b1, 8'h77});
        step();
        step();
        chk("wr_rv_count", rv_cnt, r0 + 1);

        // idle burst of 16
        d0 = done_cnt; v0 = dbg_cnt;
        kick(32'h1400, 16, 1'b1);
        @(negedge clk);
        chk("burst_busy", dbg_busy, 1);
        chk("burst_addr0", mem_addr, 32'h1400);
        step();
        wait_done(d0, 40);
        @(negedge clk);
        chk("burst_busy_fall", dbg_busy, 0);
        chk("burst_state_idle", fsm_state, IDLE);
        step();
        repeat (3) step();
        chk("burst_valid_cnt", dbg_cnt, v0 + 16);
        chk("burst_done_once", done_cnt, d0 + 1);

        // core held high during a len=4 burst
        d0 = done_cnt; v0 = dbg_cnt;
        core_req = 1'b1; core_addr = 32'h1000;
        kick(32'h1500, 4, 1'b1);
`ifdef MB8_ARB_FAIR_EN
        for (int c = 1; c <= 37; c++) begin
            @(negedge clk);
            chk("fair_gnt", core_gnt, (c % 9) != 0);
            step();
        end
        chk("fair_valid_cnt", dbg_cnt, v0 + 4);
        chk("fair_done", done_cnt, d0 + 1);
        idle_core();
        repeat (2) step();
`else
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            chk("strict_gnt", core_gnt, 1);
            chk("strict_busy", dbg_busy, 1);
            step();
        end
        chk("strict_starved", dbg_cnt, v0);
        idle_core();
        wait_done(d0, 20);
        repeat (2) step();
        chk("strict_valid_cnt", dbg_cnt, v0 + 4);
`endif

        // address wrap
        d0 = done_cnt; v0 = dbg_cnt;
        kick(32'hFFFF_FFFE, 4, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wrap_addr", mem_addr, 32'hFFFF_FFFE + 32'(k));
            step();
        end
        wait_done(d0, 10);
        repeat (2) step();
        chk("wrap_valid_cnt", dbg_cnt, v0 + 4);

        // zero-length burst
        d0 = done_cnt; v0 = dbg_cnt;
        kick(32'h1600, 0, 1'b0);
        @(negedge clk);
        chk("len0_done", dbg_done, 1);
        chk("len0_busy", dbg_busy, 0);
        step();
        @(negedge clk);
        chk("len0_done_off", dbg_done, 0);
        step();
        repeat (3) step();
        chk("len0_no_access", dbg_cnt, v0);
        chk("len0_done_once", done_cnt, d0 + 1);

        // dbg_start while busy is ignored
        d0 = done_cnt; v0 = dbg_cnt;
        kick(32'h1400, 16, 1'b1);
        repeat (3) step();
        kick(32'h3000, 2, 1'b0);
        wait_done(d0, 40);
        repeat (4) step();
        chk("busy_ign_valid", dbg_cnt, v0 + 16);
        chk("busy_ign_done", done_cnt, d0 + 1);

        // random core traffic against a random-length burst
        d0 = done_cnt; v0 = dbg_cnt;
        begin
            int rl, n;
            rl = $urandom_range(3, 9);
            kick(32'h5000 + 32'($urandom_range(0, 255)), rl, 1'b1);
            n = 0;
            while (done_cnt == d0 && n < 300) begin
                core_req  = 1'($urandom_range(0, 1));
                core_addr = 32'h6000 + 32'($urandom_range(0, 255));
                step();
                n++;
            end
            idle_core();
            chk("rand_done", (done_cnt != d0), 1);
            repeat (3) step();
            chk("rand_valid_cnt", dbg_cnt, v0 + rl);
        end

        // reset mid-burst
        d0 = done_cnt; v0 = dbg_cnt;
        kick(32'h1400, 16, 1'b1);
        begin
            int n;
            n = 0;
            while (dbg_cnt < v0 + 5 && n < 30) begin
                @(posedge clk);
                n++;
            end
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_busy", dbg_busy, 0);
        chk("mrst_dvalid", dbg_valid, 0);
        chk("mrst_ddata", dbg_data, 0);
        chk("mrst_done", dbg_done, 0);
        chk("mrst_rvalid", core_rvalid, 0);
        chk("mrst_gnt", core_gnt, 0);
        chk("mrst_mem", {mem_addr, mem_we, mem_wdata}, 0);
        chk("mrst_state", fsm_state, IDLE);
        dbg_exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) step();
        chk("mrst_no_done", done_cnt, d0);
        chk("mrst_bytes", dbg_cnt, v0 + 5);
        kick(32'h1800, 8, 1'b1);
        wait_done(d0, 30);
        repeat (2) step();
        chk("mrst_new_burst", dbg_cnt, v0 + 13);
        chk("mrst_new_done", done_cnt, d0 + 1);

        chk("dbg_q_empty", dbg_exp_q.size(), 0);
        chk("core_q_empty", core_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
